keyscan: RTL and testbench

- Drives a 4x4 matrix keypad: selects one column at a time, samples the rows, and assembles a 16-bit snapshot per scan frame.
- Debounces snapshots over several frames and publishes a stable `keys[15:0]` vector.
- `keys[15:0]` is the vector that the key encoder consumes. This block is the producing end of that interface.
- Also emits a one-cycle pulse whenever a new key press is committed.

---
 rtl/keyscan_if.sv | 24 ++
 rtl/keyscan.sv | 121 ++++++++++++
 tb/tb_keyscan.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keyscan_if.sv
// rtl/keyscan_if.sv - keypad matrix pins and debounced key-state bundle for keyscan
interface keyscan_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;
    logic        key_press;
    logic        frame_end;

    modport master (
        input  row_in,
        output col_out,
        output keys,
        output key_press,
        output frame_end
    );

    modport slave (
        output row_in,
        input  col_out,
        input  keys,
        input  key_press,
        input  frame_end
    );
endinterface

// File: rtl/keyscan.sv
// rtl/keyscan.sv - 4x4 keypad column scanner with multi-frame debounce
// Optional ghost-frame rejection is enabled by defining KEYSCAN_GHOST_REJECT_EN.
module keyscan #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic      clock,
    input  logic      reset,
    keyscan_if.master kp
);

    localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  CNT_COMMIT = 4'(DEB_FRAMES - 1);
    localparam logic [3:0]  CNT_HOLD   = 4'(DEB_FRAMES);

    logic [15:0] div_q, div_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_out_q, col_out_d;
    logic [11:0] snap_q, snap_d;
    logic [15:0] cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] keys_q, keys_d;
    logic        key_press_q, key_press_d;

    logic        last_slot;
    logic        frame_last;
    logic [3:0]  col_sample;
    logic [15:0] frame_f;
    logic        ghost;

`ifdef KEYSCAN_GHOST_REJECT_EN
    // Two columns sharing two pressed rows cannot be resolved on a diode-less matrix.
    function automatic logic is_ghost(input logic [15:0] f);
        logic       hit;
        logic [3:0] ov;
        hit = 1'b0;
        for (int c1 = 0; c1 < 3; c1++) begin
            for (int c2 = c1 + 1; c2 < 4; c2++) begin
                ov = f[c1*4 +: 4] & f[c2*4 +: 4];
                if ((ov & 4'(ov - 4'd1)) != 4'd0) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction
`endif

    always_comb begin
        last_slot  = (div_q == DIV_LAST);
        frame_last = last_slot && (col_idx_q == 2'd3);
        col_sample = ~kp.row_in;
        frame_f    = {col_sample, snap_q};
`ifdef KEYSCAN_GHOST_REJECT_EN
        ghost      = is_ghost(frame_f);
`else
        ghost      = 1'b0;
`endif

        div_d       = div_q + 16'd1;
        col_idx_d   = col_idx_q;
        snap_d      = snap_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        keys_d      = keys_q;
        key_press_d = 1'b0;

        if (last_slot) begin
            div_d     = 16'd0;
            col_idx_d = col_idx_q + 2'd1;
            if (col_idx_q != 2'd3) begin
                snap_d[{col_idx_q, 2'b00} +: 4] = col_sample;
            end
        end
        col_out_d = ~(4'b0001 << col_idx_d);

        // The last column is not stored; it completes the frame directly.
        if (frame_last) begin
            if (ghost) begin
                cnt_d = 4'd0;
            end else if (frame_f != cand_q) begin
                cand_d = frame_f;
                cnt_d  = 4'd1;
            end else if (cnt_q < CNT_COMMIT) begin
                cnt_d = cnt_q + 4'd1;
            end else if (cnt_q == CNT_COMMIT) begin
                cnt_d       = CNT_HOLD;
                keys_d      = frame_f;
                key_press_d = |(frame_f & ~keys_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q       <= 16'd0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            snap_q      <= 12'd0;
            cand_q      <= 16'd0;
            cnt_q       <= 4'd0;
            keys_q      <= 16'd0;
            key_press_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            snap_q      <= snap_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            keys_q      <= keys_d;
            key_press_q <= key_press_d;
        end
    end

    assign kp.col_out   = col_out_q;
    assign kp.keys      = keys_q;
    assign kp.key_press = key_press_q;
    assign kp.frame_end = frame_last;

endmodule

// File: tb/tb_keyscan.sv
// tb/tb_keyscan.sv - self-checking bench for keyscan against a frame-level keypad model
module tb_keyscan;

    localparam int D   = 4;
    localparam int DEB = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    keyscan_if kp ();

    keyscan #(.SCAN_DIV(D), .DEB_FRAMES(DEB)) dut (
        .clock (clk),
        .reset (resetn),
        .kp    (kp)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          t;
    logic [15:0] pressed;
    logic [15:0] m_keys;
    logic [15:0] m_snap;
    logic [15:0] m_last;
    int          m_run;
    logic        m_press;

    function automatic logic ref_ghost(input logic [15:0] f);
`ifdef KEYSCAN_GHOST_REJECT_EN
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                int shared;
                shared = 0;
                for (int r = 0; r < 4; r++) begin
                    if (a != b && f[a*4+r] && f[b*4+r]) shared++;
                end
                if (shared >= 2) return 1'b1;
            end
        end
        return 1'b0;
`else
        return (f != f);
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        m_keys  = 16'h0;
        m_snap  = 16'h0;
        m_last  = 16'h0;
        m_run   = 0;
        m_press = 1'b0;
    endtask

    // A frame commits once DEB consecutive non-ghost frames have been identical.
    task automatic frame_done(input logic [15:0] f);
        if (ref_ghost(f)) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && f == m_last) m_run++;
            else begin
                m_run  = 1;
                m_last = f;
            end
            if (m_run >= DEB) begin
                m_press = |(f & ~m_keys);
                m_keys  = f;
            end
        end
    endtask

    task automatic model_step();
        int col;
        col     = (t / D) % 4;
        m_press = 1'b0;
        if (t % D == D - 1) begin
            m_snap[col*4 +: 4] = pressed[col*4 +: 4];
            if (col == 3) frame_done(m_snap);
        end
        t++;
    endtask

    task automatic cycle();
        int         col;
        logic [3:0] one;
        logic [3:0] exp_col;
        col       = (t / D) % 4;
        one       = 4'b0001;
        exp_col   = ~(one << col);
        kp.row_in = ~pressed[col*4 +: 4];
        chk("col_out",   {12'h0, kp.col_out},   {12'h0, exp_col});
        chk("frame_end", {15'h0, kp.frame_end}, {15'h0, (t % D == D - 1) && (col == 3)});
        chk("keys",      kp.keys,               m_keys);
        chk("key_press", {15'h0, kp.key_press}, {15'h0, m_press});
        @(posedge clk);
        if (!resetn) model_reset();
        else         model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    initial begin
        pressed   = 16'h0;
        kp.row_in = 4'hF;
        t         = 0;
        resetn    = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        chk("rst_col_out", {12'h0, kp.col_out}, 16'h000E);
        chk("rst_keys", kp.keys, 16'h0);
        resetn = 1'b1;

        // idle scan
        run(100);
        chk("idle_keys", kp.keys, 16'h0);

        // key (2,1) held from reset release commits at cycle 31
        pressed = 16'h0200;
        do_reset();
        run(32);
        chk("held_keys", kp.keys, 16'h0200);
        chk("held_press", {15'h0, kp.key_press}, 16'h1);
        run(1);
        chk("held_press_end", {15'h0, kp.key_press}, 16'h0);
        run(30);
        chk("held_stable", kp.keys, 16'h0200);

        // bounce every frame, then settle
        pressed = 16'h0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            run(16);
        end
        chk("bounce_keys", kp.keys, 16'h0);
        pressed = 16'h0200;
        run(32);
        chk("settled_keys", kp.keys, 16'h0200);

        // add (0,0): pulse; release both: no pulse
        pressed = 16'h0201;
        run(32);
        chk("add_keys", kp.keys, 16'h0201);
        chk("add_press", {15'h0, kp.key_press}, 16'h1);
        pressed = 16'h0;
        run(32);
        chk("rel_keys", kp.keys, 16'h0);
        chk("rel_press", {15'h0, kp.key_press}, 16'h0);

        // reset mid-frame
        pressed = 16'h0200;
        run(32);
        chk("pre_rst_keys", kp.keys, 16'h0200);
        run(5);
        do_reset();
        chk("mid_rst_keys", kp.keys, 16'h0);
        chk("mid_rst_col", {12'h0, kp.col_out}, 16'h000E);
        chk("mid_rst_press", {15'h0, kp.key_press}, 16'h0);
        run(16);
        chk("one_frame_keys", kp.keys, 16'h0);
        run(16);
        chk("recommit_keys", kp.keys, 16'h0200);

        // 2x2 block: ghost pattern
        pressed = 16'h0033;
        do_reset();
        run(48);
`ifdef KEYSCAN_GHOST_REJECT_EN
        chk("ghost_keys", kp.keys, 16'h0);
`else
        chk("ghost_keys", kp.keys, 16'h0033);
`endif

        // randomized keypad activity, including mid-frame changes and resets
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 3))
                0: pressed = 16'h0;
                1: pressed = 16'h1 << $urandom_range(0, 15);
                2: pressed = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) do_reset();
            run($urandom_range(1, 40));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
